// File: rtl/phy_tx_arbiter_if.sv
// Requester-to-PHY bus of the transmit arbiter: four requester lanes in,
// one registered word stream plus grant status out.
interface phy_tx_arbiter_if #(
    parameter int WIDTH = 32
);
    logic [3:0]         req_valid;
    logic [4*WIDTH-1:0] req_data;
    logic [3:0]         req_last;
    logic [3:0]         req_ready;
    logic [WIDTH-1:0]   data_out;
    logic               valid_out;
    logic [3:0]         grant;
    logic               busy;

    modport master (
        output req_valid, req_data, req_last,
        input  req_ready, data_out, valid_out, grant, busy
    );

    modport slave (
        input  req_valid, req_data, req_last,
        output req_ready, data_out, valid_out, grant, busy
    );
endinterface

// File: rtl/phy_tx_arbiter.sv
// Round-robin arbiter feeding one of four requesters into the PHY transmit path.
// A grant lasts until last, MAX_BURST words, or STALL_MAX idle cycles.
module phy_tx_arbiter #(
    parameter int               WIDTH     = 32,
    parameter int               MAX_BURST = 8,
    parameter int               STALL_MAX = 4,
    parameter logic [WIDTH-1:0] IDLE_WORD = 32'hBCBC_BCBC
) (
    input logic            clk_2f,
    input logic            reset,
    phy_tx_arbiter_if.slave bus
);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int SW = $clog2(STALL_MAX + 1);

    typedef enum logic {IDLE, XFER} state_e;

    state_e           state_q, state_d;
    logic [3:0]       grant_q, grant_d;
    logic [1:0]       g_q, g_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]    burst_q, burst_d;
    logic [SW-1:0]    stall_q, stall_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    logic       sel_found;
    logic [1:0] sel_idx;
    logic [1:0] cand;
    logic [3:0] ready;
    logic       hs;
    logic [BW-1:0] burst_inc;
    logic [SW-1:0] stall_inc;

    // Ready is gated by reset so nothing can be accepted in a cycle that is being aborted.
    assign ready     = (state_q == XFER && !reset) ? grant_q : 4'b0000;
    assign hs        = |(bus.req_valid & ready);
    assign burst_inc = burst_q + 1'b1;
    assign stall_inc = stall_q + 1'b1;

    // First valid requester at or after rr_ptr, wrapping modulo 4.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        sel_found = 1'b0;
        sel_idx   = rr_ptr_q;
        cand      = rr_ptr_q;
        for (int k = 0; k < 4; k++) begin
            cand = rr_ptr_q + 2'(k);
            if (!sel_found && bus.req_valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        g_d      = g_q;
        rr_ptr_d = rr_ptr_q;
        burst_d  = burst_q;
        stall_d  = stall_q;
        data_d   = IDLE_WORD;
        valid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d = XFER;
                    g_d     = sel_idx;
                    grant_d = 4'b0001 << sel_idx;
                    burst_d = '0;
                    stall_d = '0;
                end
            end
            XFER: begin
                if (hs) begin
                    data_d  = bus.req_data[g_q*WIDTH +: WIDTH];
                    valid_d = 1'b1;
                    burst_d = burst_inc;
                    stall_d = '0;
                    if (bus.req_last[g_q] || burst_inc == BW'(MAX_BURST)) begin
                        state_d  = IDLE;
                        grant_d  = 4'b0000;
                        rr_ptr_d = g_q + 2'd1;
                    end
                end else begin
                    stall_d = stall_inc;
                    if (stall_inc == SW'(STALL_MAX)) begin
                        state_d  = IDLE;
                        grant_d  = 4'b0000;
                        rr_ptr_d = g_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_2f) begin
        // NOTE: non-blocking assignments so all state updates see pre-edge values.
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= 4'b0000;
            g_q      <= 2'd0;
            rr_ptr_q <= 2'd0;
            burst_q  <= '0;
            stall_q  <= '0;
            data_q   <= IDLE_WORD;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            g_q      <= g_d;
            rr_ptr_q <= rr_ptr_d;
            burst_q  <= burst_d;
            stall_q  <= stall_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.req_ready = ready;
    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.grant     = grant_q;
    assign bus.busy      = (state_q == XFER);
endmodule

// File: tb/tb_phy_tx_arbiter.sv
// Directed bench for phy_tx_arbiter: grants, bursts, stall release, reset abort.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_phy_tx_arbiter;
    localparam logic [31:0] IDLE_W = 32'hBCBC_BCBC;

    logic clk_2f = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    phy_tx_arbiter_if #(.WIDTH(32)) bus ();

    phy_tx_arbiter #(.WIDTH(32)) dut (
        .clk_2f (clk_2f),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_2f = ~clk_2f;

    task automatic tick();
        @(posedge clk_2f);
        #1;
    endtask

    task automatic set_data(input int i, input logic [31:0] v);
        bus.req_data[i*32 +: 32] = v;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.req_valid = 4'b0000;
        bus.req_data  = '0;
        bus.req_last  = 4'b0000;
        tick();
        tick();
        check("rst_grant", 32'(bus.grant), 32'h0);
        check("rst_valid", 32'(bus.valid_out), 32'h0);
        check("rst_data", bus.data_out, IDLE_W);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_ready", 32'(bus.req_ready), 32'h0);

        // Single requester, three words, last on the third
        reset = 1'b0;
        bus.req_valid = 4'b0001;
        set_data(0, 32'hA000_0001);
        tick();
        check("t1_grant", 32'(bus.grant), 32'h1);
        check("t1_busy", 32'(bus.busy), 32'h1);
        check("t1_ready", 32'(bus.req_ready), 32'h1);
        check("t1_arb_valid", 32'(bus.valid_out), 32'h0);
        tick();
        check("t1_a1", bus.data_out, 32'hA000_0001);
        check("t1_a1_valid", 32'(bus.valid_out), 32'h1);
        set_data(0, 32'hA000_0002);
        tick();
        check("t1_a2", bus.data_out, 32'hA000_0002);
        set_data(0, 32'hA000_0003);
        bus.req_last = 4'b0001;
        tick();
        check("t1_a3", bus.data_out, 32'hA000_0003);
        check("t1_a3_valid", 32'(bus.valid_out), 32'h1);
        check("t1_rel_grant", 32'(bus.grant), 32'h0);
        check("t1_rel_busy", 32'(bus.busy), 32'h0);
        bus.req_valid = 4'b0000;
        bus.req_last  = 4'b0000;
        tick();
        check("t1_idle_data", bus.data_out, IDLE_W);
        check("t1_idle_valid", 32'(bus.valid_out), 32'h0);
        // rr_ptr is now 1: with 0 and 1 both requesting, 1 wins
        bus.req_valid = 4'b0011;
        bus.req_last  = 4'b0010;
        set_data(1, 32'hB000_0001);
        tick();
        check("t1_rr_grant", 32'(bus.grant), 32'h2);
        tick();
        check("t1_rr_data", bus.data_out, 32'hB000_0001);
        bus.req_valid = 4'b0000;
        bus.req_last  = 4'b0000;
        tick();

        // All four streaming single-word packets after a reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_last  = 4'b1111;
        for (int i = 0; i < 4; i++) set_data(i, 32'hD0D0_0000 + 32'(i));
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t2_grant", 32'(bus.grant), 32'(4'b0001 << (k % 4)));
            check("t2_arb_valid", 32'(bus.valid_out), 32'h0);
            tick();
            check("t2_data", bus.data_out, 32'hD0D0_0000 + 32'(k % 4));
            check("t2_rel_grant", 32'(bus.grant), 32'h0);
        end
        bus.req_valid = 4'b0000;
        bus.req_last  = 4'b0000;
        tick();

        // Requester 2 alone, 12 words, no last: 8 + regrant + 4, then stall out
        bus.req_valid = 4'b0100;
        tick();
        check("t3_grant", 32'(bus.grant), 32'h4);
        for (int w = 0; w < 8; w++) begin
            set_data(2, 32'h2200_0000 + 32'(w));
            tick();
            check("t3_word", bus.data_out, 32'h2200_0000 + 32'(w));
            check("t3_word_grant", 32'(bus.grant), (w == 7) ? 32'h0 : 32'h4);
        end
        tick();
        check("t3_regrant", 32'(bus.grant), 32'h4);
        check("t3_gap_valid", 32'(bus.valid_out), 32'h0);
        check("t3_gap_data", bus.data_out, IDLE_W);
        for (int w = 8; w < 12; w++) begin
            set_data(2, 32'h2200_0000 + 32'(w));
            tick();
            check("t3_word2", bus.data_out, 32'h2200_0000 + 32'(w));
        end
        bus.req_valid = 4'b0000;
        set_data(2, 32'hDEAD_BEEF);
        for (int s = 1; s <= 4; s++) begin
            tick();
            check("t3_stall_data", bus.data_out, IDLE_W);
            check("t3_stall_busy", 32'(bus.busy), (s < 4) ? 32'h1 : 32'h0);
        end

        // Requester 1: two words then silence forces release after 4 cycles
        bus.req_valid = 4'b0010;
        tick();
        check("t4_grant", 32'(bus.grant), 32'h2);
        set_data(1, 32'h1100_0000);
        tick();
        check("t4_w0", bus.data_out, 32'h1100_0000);
        set_data(1, 32'h1100_0001);
        tick();
        check("t4_w1", bus.data_out, 32'h1100_0001);
        bus.req_valid = 4'b0000;
        bus.req_last  = 4'b0010;
        set_data(1, 32'hDEAD_BEEF);
        for (int s = 1; s <= 4; s++) begin
            tick();
            check("t4_stall_valid", 32'(bus.valid_out), 32'h0);
            check("t4_stall_data", bus.data_out, IDLE_W);
            check("t4_stall_grant", 32'(bus.grant), (s < 4) ? 32'h2 : 32'h0);
            check("t4_stall_busy", 32'(bus.busy), (s < 4) ? 32'h1 : 32'h0);
        end
        bus.req_last = 4'b0000;

        // Reset during the third word of a requester-2 burst
        bus.req_valid = 4'b0100;
        tick();
        check("t5_grant", 32'(bus.grant), 32'h4);
        set_data(2, 32'h3300_0000);
        tick();
        check("t5_w0", bus.data_out, 32'h3300_0000);
        set_data(2, 32'h3300_0001);
        tick();
        check("t5_w1", bus.data_out, 32'h3300_0001);
        set_data(2, 32'h3300_0002);
        reset = 1'b1;
        #1;
        check("t5_rst_ready", 32'(bus.req_ready), 32'h0);
        tick();
        check("t5_rst_data", bus.data_out, IDLE_W);
        check("t5_rst_valid", 32'(bus.valid_out), 32'h0);
        check("t5_rst_grant", 32'(bus.grant), 32'h0);
        check("t5_rst_busy", 32'(bus.busy), 32'h0);
        reset = 1'b0;
        bus.req_valid = 4'b0101;
        bus.req_last  = 4'b0101;
        set_data(0, 32'hE000_0000);
        set_data(2, 32'hE000_0002);
        tick();
        check("t5_post_grant", 32'(bus.grant), 32'h1);
        tick();
        check("t5_post_data", bus.data_out, 32'hE000_0000);
        bus.req_valid = 4'b0000;
        bus.req_last  = 4'b0000;
        tick();

        // Requester 0, last on the 8th word; requester 3 toggles meanwhile
        bus.req_valid = 4'b0001;
        tick();
        check("t6_grant", 32'(bus.grant), 32'h1);
        for (int w = 0; w < 8; w++) begin
            bus.req_valid = (w % 2 == 1) ? 4'b1001 : 4'b0001;
            bus.req_last  = (w == 7) ? 4'b0001 : 4'b0000;
            set_data(0, 32'h4400_0000 + 32'(w));
            #1;
            check("t6_ready", 32'(bus.req_ready), 32'h1);
            tick();
            check("t6_word", bus.data_out, 32'h4400_0000 + 32'(w));
            check("t6_word_grant", 32'(bus.grant), (w == 7) ? 32'h0 : 32'h1);
        end
        bus.req_valid = 4'b0011;
        bus.req_last  = 4'b0010;
        set_data(1, 32'h5500_0001);
        tick();
        check("t6_next_grant", 32'(bus.grant), 32'h2);
        check("t6_gap_valid", 32'(bus.valid_out), 32'h0);
        tick();
        check("t6_next_data", bus.data_out, 32'h5500_0001);
        bus.req_valid = 4'b0000;
        bus.req_last  = 4'b0000;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
